// File: rtl/proc_pkg.sv
// Shared processor definitions: state codes (also decoded by the control unit),
// opcode constants and the default opcode width.
package proc_pkg;

  localparam int OPC_W_DEF = 8;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'd0,
    ST_FETCH1    = 6'd1,
    ST_FETCH2    = 6'd2,
    ST_FETCH3    = 6'd3,
    ST_FETCH4    = 6'd4,
    ST_FETCH5    = 6'd5,
    ST_FETCH6    = 6'd6,
    ST_LDR11     = 6'd7,
    ST_LDR12     = 6'd8,
    ST_LDR13     = 6'd9,
    ST_LDR14     = 6'd10,
    ST_LDR21     = 6'd11,
    ST_LDR22     = 6'd12,
    ST_LDR23     = 6'd13,
    ST_LDR24     = 6'd14,
    ST_STAC1     = 6'd15,
    ST_STAC2     = 6'd16,
    ST_STAC3     = 6'd17,
    ST_STAC4     = 6'd18,
    ST_ADD       = 6'd19,
    ST_MUL       = 6'd20,
    ST_STEP_WAIT = 6'd21
  } state_e;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDR1 = 8'h01;
  localparam logic [7:0] OP_LDR2 = 8'h02;
  localparam logic [7:0] OP_STAC = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_MUL  = 8'h05;
  localparam logic [7:0] OP_END  = 8'hFF;

endpackage

// File: rtl/opcode_dispatch.sv
// Combinational opcode decode used at the fetch6 decision: first microstate of the
// instruction's chain plus NOP/END/illegal classification.
module opcode_dispatch
  import proc_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic [OPC_W-1:0] opcode,
  output state_e           first_state,
  output logic             is_nop,
  output logic             is_end,
  output logic             is_illegal
);

  always_comb begin
    first_state = ST_FETCH1;
    is_nop      = 1'b0;
    is_end      = 1'b0;
    is_illegal  = 1'b0;
    if (opcode == OPC_W'(OP_NOP))       is_nop = 1'b1;
    else if (opcode == OPC_W'(OP_LDR1)) first_state = ST_LDR11;
    else if (opcode == OPC_W'(OP_LDR2)) first_state = ST_LDR21;
    else if (opcode == OPC_W'(OP_STAC)) first_state = ST_STAC1;
    else if (opcode == OPC_W'(OP_ADD))  first_state = ST_ADD;
    else if (opcode == OPC_W'(OP_MUL))  first_state = ST_MUL;
    else if (opcode == OPC_W'(OP_END))  is_end = 1'b1;
    else                                is_illegal = 1'b1;
  end

endmodule

// File: rtl/state_sequencer.sv
// Processor state sequencer: fetch, opcode dispatch, microstate chains, stall,
// halt/illegal pulses and retire counter. Optional SEQ_SINGLE_STEP_EN adds step/step_wait.
module state_sequencer
  import proc_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [OPC_W-1:0] opcode,
  output logic [5:0]       state,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e RET_ST = ST_STEP_WAIT;
`else
  localparam state_e RET_ST = ST_FETCH1;
`endif

  state_e state_q;
  state_e first_state;
  logic   is_nop, is_end, is_illegal;

  opcode_dispatch #(.OPC_W(OPC_W)) u_dispatch (
    .opcode      (opcode),
    .first_state (first_state),
    .is_nop      (is_nop),
    .is_end      (is_end),
    .is_illegal  (is_illegal)
  );

  // start is sampled only in idle; stall freezes every other state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start) begin
          state_q <= ST_FETCH1;
          busy    <= 1'b1;
        end
      end else if (!stall) begin
        busy <= 1'b1;
        case (state_q)
          ST_FETCH1: state_q <= ST_FETCH2;
          ST_FETCH2: state_q <= ST_FETCH3;
          ST_FETCH3: state_q <= ST_FETCH4;
          ST_FETCH4: state_q <= ST_FETCH5;
          ST_FETCH5: state_q <= ST_FETCH6;
          ST_FETCH6: begin
            if (is_end) begin
              state_q <= ST_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (is_illegal) begin
              state_q <= RET_ST;
              illegal <= 1'b1;
            end else if (is_nop) begin
              state_q     <= RET_ST;
              instr_count <= instr_count + 1'b1;
            end else begin
              state_q <= first_state;
            end
          end
          ST_LDR11: state_q <= ST_LDR12;
          ST_LDR12: state_q <= ST_LDR13;
          ST_LDR13: state_q <= ST_LDR14;
          ST_LDR21: state_q <= ST_LDR22;
          ST_LDR22: state_q <= ST_LDR23;
          ST_LDR23: state_q <= ST_LDR24;
          ST_STAC1: state_q <= ST_STAC2;
          ST_STAC2: state_q <= ST_STAC3;
          ST_STAC3: state_q <= ST_STAC4;
          ST_LDR14, ST_LDR24, ST_STAC4, ST_ADD, ST_MUL: begin
            state_q     <= RET_ST;
            instr_count <= instr_count + 1'b1;
          end
`ifdef SEQ_SINGLE_STEP_EN
          ST_STEP_WAIT: if (step) state_q <= ST_FETCH1;
`endif
          // Unused codes (including 21 without single-step) recover to idle.
          default: begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Randomized bench for state_sequencer: directed plan sequences plus random traffic,
// all checked against a phase-based reference model.
module tb_state_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [5:0]  state;
  logic        busy, done, illegal;
  logic [15:0] instr_count;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  state_sequencer #(.OPC_W(8), .CNT_W(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .stall       (stall),
`ifdef SEQ_SINGLE_STEP_EN
    .step        (step),
`endif
    .opcode      (opcode),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Reference model: where the processor is (idle / fetch step k / k-th microstate of a chain).
  localparam int P_IDLE = 0, P_FETCH = 1, P_CHAIN = 2, P_WAIT = 3;
  int          chain_base[6] = '{0, 7, 11, 15, 19, 20};
  int          chain_len[6]  = '{0, 4, 4, 4, 1, 1};
  int          m_phase, m_k, m_base, m_len;
  logic [15:0] m_count;
  logic        m_done, m_ill;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_code();
    case (m_phase)
      P_FETCH: return m_k;
      P_CHAIN: return m_base + m_k;
      P_WAIT:  return 21;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_k = 0; m_base = 0; m_len = 0;
    m_count = '0; m_done = 1'b0; m_ill = 1'b0;
  endtask

  task automatic model_back_to_fetch();
`ifdef SEQ_SINGLE_STEP_EN
    m_phase = P_WAIT;
`else
    m_phase = P_FETCH; m_k = 1;
`endif
  endtask

  task automatic model_step(input logic st, input logic sl, input logic [7:0] op);
    m_done = 1'b0;
    m_ill  = 1'b0;
    if (m_phase == P_IDLE) begin
      if (st) begin m_phase = P_FETCH; m_k = 1; end
    end else if (!sl) begin
      case (m_phase)
        P_FETCH: begin
          if (m_k < 6) m_k++;
          else if (op == 8'hFF) begin m_phase = P_IDLE; m_done = 1'b1; end
          else if (op == 8'h00) begin m_count++; model_back_to_fetch(); end
          else if (op <= 8'h05) begin
            m_phase = P_CHAIN; m_k = 0;
            m_base = chain_base[op]; m_len = chain_len[op];
          end else begin m_ill = 1'b1; model_back_to_fetch(); end
        end
        P_CHAIN: begin
          if (m_k + 1 < m_len) m_k++;
          else begin m_count++; model_back_to_fetch(); end
        end
        P_WAIT: begin
`ifdef SEQ_SINGLE_STEP_EN
          if (step) begin m_phase = P_FETCH; m_k = 1; end
`endif
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic compare_model();
    check_eq("state", state, m_code());
    check_eq("busy", busy, m_code() != 0);
    check_eq("done", done, m_done);
    check_eq("illegal", illegal, m_ill);
    check_eq("instr_count", instr_count, m_count);
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge.
  task automatic tick(input logic st, input logic sl, input logic [7:0] op);
    start = st; stall = sl; opcode = op;
    model_step(st, sl, op);
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic run_fetch(input logic [7:0] op);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, op);
  endtask

  initial begin
    int add_trace[8] = '{1, 2, 3, 4, 5, 6, 19, 1};
    int ldr_trace[8] = '{7, 8, 8, 8, 8, 9, 10, 1};
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    compare_model();

`ifndef SEQ_SINGLE_STEP_EN
    // ADD after a one-cycle start pulse.
    for (int i = 0; i < 8; i++) begin
      tick(i == 0, 1'b0, 8'h04);
      check_eq("add_trace", state, add_trace[i]);
    end
    check_eq("add_count", instr_count, 16'd1);

    // LDR1 with a 3-cycle stall holding ldr12.
    run_fetch(8'h01);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, (i >= 2 && i <= 4), 8'h01);
      check_eq("ldr_trace", state, ldr_trace[i]);
    end
    check_eq("ldr_count", instr_count, 16'd2);

    // END dispatch: idle with a single done pulse; start in the same cycle loses.
    run_fetch(8'hFF);
    tick(1'b1, 1'b0, 8'hFF);
    check_eq("end_state", state, 0);
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 0);
    tick(1'b0, 1'b0, 8'h00);
    check_eq("end_done_once", done, 0);
    check_eq("end_count", instr_count, 16'd2);

    // Illegal opcode: back to fetch1, one illegal pulse, no retire.
    tick(1'b1, 1'b0, 8'h37);
    run_fetch(8'h37);
    tick(1'b0, 1'b0, 8'h37);
    check_eq("ill_state", state, 1);
    check_eq("ill_pulse", illegal, 1);
    tick(1'b0, 1'b0, 8'h00);
    check_eq("ill_pulse_once", illegal, 0);
    check_eq("ill_count", instr_count, 16'd2);
`else
    // MUL with single-step: holds step_wait until step is raised.
    tick(1'b1, 1'b0, 8'h05);
    run_fetch(8'h05);
    check_eq("ss_fetch6", state, 6);
    tick(1'b0, 1'b0, 8'h05);
    check_eq("ss_mul", state, 20);
    tick(1'b0, 1'b0, 8'h05);
    check_eq("ss_wait", state, 21);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      check_eq("ss_hold", state, 21);
    end
    step = 1'b1;
    tick(1'b0, 1'b0, 8'h00);
    step = 1'b0;
    check_eq("ss_release", state, 1);
`endif

    // Asynchronous reset in stac2, observed before the next clock edge.
    while (m_phase != P_FETCH || m_k != 1) tick(1'b1, 1'b0, 8'h00);
    run_fetch(8'h03);
    tick(1'b0, 1'b0, 8'h03);
    tick(1'b0, 1'b0, 8'h03);
    check_eq("stac2_state", state, 16);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_state", state, 0);
    check_eq("async_count", instr_count, 16'd0);
    check_eq("async_busy", busy, 0);
    model_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick(1'b1, 1'b0, 8'h00);
    check_eq("restart_fetch1", state, 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(0, 15);
      if (r < 10) op = 8'(r % 6);
      else if (r == 10) op = 8'hFF;
      else op = 8'($urandom_range(6, 254));
`ifdef SEQ_SINGLE_STEP_EN
      step = ($urandom_range(0, 2) == 0);
`endif
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, op);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
